// File: rtl/scan_anillo_n_if.sv
// Bus bundle for scan_anillo_n: digit values in, scan/anode drive out.
// With SCAN_DIMMING_EN defined the bundle also carries the i_Bright level.
interface scan_anillo_n_if #(
    parameter int N_DIGITS = 4,
    parameter int DIG_W    = 4
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                      i_En;
    logic [N_DIGITS*DIG_W-1:0] i_Data;
    logic [N_DIGITS-1:0]       i_DpMask;
`ifdef SCAN_DIMMING_EN
    logic [3:0]                i_Bright;
`endif
    logic [SEL_W-1:0]          o_Sel;
    logic [N_DIGITS-1:0]       o_Anodos;
    logic [DIG_W-1:0]          o_Digit;
    logic                      o_Dp;
    logic                      o_Tick;
    logic                      o_Frame;

`ifdef SCAN_DIMMING_EN
    modport master (output i_En, i_Data, i_DpMask, i_Bright,
                    input  o_Sel, o_Anodos, o_Digit, o_Dp, o_Tick, o_Frame);
    modport slave  (input  i_En, i_Data, i_DpMask, i_Bright,
                    output o_Sel, o_Anodos, o_Digit, o_Dp, o_Tick, o_Frame);
`else
    modport master (output i_En, i_Data, i_DpMask,
                    input  o_Sel, o_Anodos, o_Digit, o_Dp, o_Tick, o_Frame);
    modport slave  (input  i_En, i_Data, i_DpMask,
                    output o_Sel, o_Anodos, o_Digit, o_Dp, o_Tick, o_Frame);
`endif
endinterface

// File: rtl/scan_anillo_n.sv
// Multiplexed display scanner: prescaled slots, leading blank time, frame snapshot.
// Optional SCAN_DIMMING_EN adds i_Bright to shorten the on-time of each slot.
module scan_anillo_n #(
    parameter int N_DIGITS  = 4,
    parameter int DIG_W     = 4,
    parameter int PRESC     = 50000,
    parameter int BLANK     = 16,
    parameter int ANODE_ACT = 1
) (
    input logic            i_Clk,
    input logic            i_Reset,
    scan_anillo_n_if.slave bus
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW    = $clog2(PRESC);

    localparam logic [PW-1:0]       P_LAST   = PW'(PRESC - 1);
    localparam logic [SEL_W-1:0]    SEL_LAST = SEL_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{ANODE_ACT == 0}};
    localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [31:0]         BLANK_U  = 32'(BLANK);
    localparam logic [31:0]         SPAN_U   = 32'(PRESC - BLANK);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             p_q, p_d, p_inc;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [N_DIGITS*DIG_W-1:0] snap_dat_q, snap_dat_d;
    logic [N_DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]       an_q, an_d;
    logic [DIG_W-1:0]          dig_q, dig_d;
    logic                      dp_q, dp_d;
    logic                      tick_q, tick_d;
    logic                      frame_q, frame_d;
    logic [31:0]               on_len;
    logic [31:0]               p_ext;

`ifdef SCAN_DIMMING_EN
    logic [3:0] bright_q, bright_d;
    assign on_len = (SPAN_U * (32'(bright_q) + 32'd1)) >> 4;
`else
    assign on_len = SPAN_U;
`endif

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        sel_d      = sel_q;
        snap_dat_d = snap_dat_q;
        snap_dp_d  = snap_dp_q;
        an_d       = AN_OFF;
        dig_d      = dig_q;
        dp_d       = dp_q;
        tick_d     = 1'b0;
        frame_d    = 1'b0;
        p_inc      = p_q + 1'b1;
        p_ext      = 32'(p_inc);
`ifdef SCAN_DIMMING_EN
        bright_d   = bright_q;
`endif
        if (!bus.i_En) begin
            state_d = S_IDLE;
            p_d     = '0;
            sel_d   = '0;
            dig_d   = snap_dat_q[DIG_W-1:0];
            dp_d    = snap_dp_q[0];
        end else if (state_q == S_IDLE || p_q == P_LAST) begin
            // Slot start: digit/dp are loaded here so they stay put through blanking.
            state_d = S_BLANK;
            p_d     = '0;
            tick_d  = 1'b1;
            sel_d   = (state_q == S_IDLE || sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            if (sel_d == '0) begin
                frame_d    = 1'b1;
                snap_dat_d = bus.i_Data;
                snap_dp_d  = bus.i_DpMask;
            end
`ifdef SCAN_DIMMING_EN
            bright_d = bus.i_Bright;
`endif
            dig_d = snap_dat_d[sel_d*DIG_W +: DIG_W];
            dp_d  = snap_dp_d[sel_d];
        end else begin
            p_d = p_inc;
            if (p_ext >= BLANK_U && p_ext < BLANK_U + on_len)
                state_d = S_SHOW;
            else
                state_d = S_BLANK;
            if (state_d == S_SHOW)
                an_d = (AN_ONE << sel_q) ^ AN_OFF;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            sel_q      <= '0;
            snap_dat_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= AN_OFF;
            dig_q      <= '0;
            dp_q       <= 1'b0;
            tick_q     <= 1'b0;
            frame_q    <= 1'b0;
`ifdef SCAN_DIMMING_EN
            bright_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            sel_q      <= sel_d;
            snap_dat_q <= snap_dat_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            dig_q      <= dig_d;
            dp_q       <= dp_d;
            tick_q     <= tick_d;
            frame_q    <= frame_d;
`ifdef SCAN_DIMMING_EN
            bright_q   <= bright_d;
`endif
        end
    end

    assign bus.o_Sel    = sel_q;
    assign bus.o_Anodos = an_q;
    assign bus.o_Digit  = dig_q;
    assign bus.o_Dp     = dp_q;
    assign bus.o_Tick   = tick_q;
    assign bus.o_Frame  = frame_q;
endmodule

// File: tb/tb_scan_anillo_n.sv
// Self-checking bench for scan_anillo_n: directed table, hand sequences, random vs model.
// Build with SCAN_DIMMING_EN defined to also exercise the dimming instance.
module tb_scan_anillo_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    scan_anillo_n_if #(.N_DIGITS(3), .DIG_W(4)) ifa ();
    scan_anillo_n_if #(.N_DIGITS(4), .DIG_W(4)) ifb ();

    scan_anillo_n #(.N_DIGITS(3), .DIG_W(4), .PRESC(8), .BLANK(2), .ANODE_ACT(1))
        dut_a (.i_Clk(clk), .i_Reset(rst), .bus(ifa));
    scan_anillo_n #(.N_DIGITS(4), .DIG_W(4), .PRESC(8), .BLANK(2), .ANODE_ACT(0))
        dut_b (.i_Clk(clk), .i_Reset(rst), .bus(ifb));
`ifdef SCAN_DIMMING_EN
    scan_anillo_n_if #(.N_DIGITS(3), .DIG_W(4)) ifc ();
    scan_anillo_n #(.N_DIGITS(3), .DIG_W(4), .PRESC(34), .BLANK(2), .ANODE_ACT(1))
        dut_c (.i_Clk(clk), .i_Reset(rst), .bus(ifc));
`endif

    // Reference: c counts enabled edges since the scan started; everything else is arithmetic on c.
    typedef struct {
        bit          idle;
        int          c;
        logic [31:0] snap;
        logic [7:0]  snapdp;
        int          bright;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mreset();
        mdl_t m;
        m.idle = 1'b1; m.c = 0; m.snap = '0; m.snapdp = '0; m.bright = 15;
        return m;
    endfunction

    task automatic mstep(inout mdl_t m, input int presc, input int n, input bit en,
                         input logic [31:0] data, input logic [7:0] dp, input int br);
        if (!en) begin
            m.idle = 1'b1; m.c = 0;
        end else if (m.idle) begin
            m.idle = 1'b0; m.c = 0;
        end else begin
            m.c++;
        end
        if (!m.idle && (m.c % presc) == 0) begin
            m.bright = br;
            if (((m.c / presc) % n) == 0) begin
                m.snap = data; m.snapdp = dp;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string pfx, input mdl_t m, input int presc, input int blank,
                           input int n, input int act, input logic [31:0] sel,
                           input logic [31:0] an, input logic [31:0] dig, input logic [31:0] dp,
                           input logic [31:0] tk, input logic [31:0] fr);
        int off, es, ea, ed, ep, et, ef, p, l;
        off = act ? 0 : ((1 << n) - 1);
        if (m.idle) begin
            es = 0; ea = off; et = 0; ef = 0;
            ed = int'(m.snap & 32'hF); ep = int'(m.snapdp & 8'h1);
        end else begin
            p  = m.c % presc;
            es = (m.c / presc) % n;
            l  = ((presc - blank) * (m.bright + 1)) >> 4;
            if (p >= blank && p < blank + l)
                ea = act ? (1 << es) : (off & ~(1 << es));
            else
                ea = off;
            ed = int'((m.snap >> (4 * es)) & 32'hF);
            ep = int'((m.snapdp >> es) & 8'h1);
            et = (p == 0) ? 1 : 0;
            ef = (p == 0 && es == 0) ? 1 : 0;
        end
        chk({pfx, ".sel"}, sel, es);
        chk({pfx, ".anodos"}, an, ea);
        chk({pfx, ".digit"}, dig, ed);
        chk({pfx, ".dp"}, dp, ep);
        chk({pfx, ".tick"}, tk, et);
        chk({pfx, ".frame"}, fr, ef);
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep(ma, 8, 3, ifa.i_En, 32'(ifa.i_Data), 8'(ifa.i_DpMask), 15);
        mstep(mb, 8, 4, ifb.i_En, 32'(ifb.i_Data), 8'(ifb.i_DpMask), 15);
`ifdef SCAN_DIMMING_EN
        mstep(mc, 34, 3, ifc.i_En, 32'(ifc.i_Data), 8'(ifc.i_DpMask), int'(ifc.i_Bright));
`endif
        #1;
    endtask

    task automatic check_all();
        chk_dut("A", ma, 8, 2, 3, 1, 32'(ifa.o_Sel), 32'(ifa.o_Anodos), 32'(ifa.o_Digit),
                32'(ifa.o_Dp), 32'(ifa.o_Tick), 32'(ifa.o_Frame));
        chk_dut("B", mb, 8, 2, 4, 0, 32'(ifb.o_Sel), 32'(ifb.o_Anodos), 32'(ifb.o_Digit),
                32'(ifb.o_Dp), 32'(ifb.o_Tick), 32'(ifb.o_Frame));
`ifdef SCAN_DIMMING_EN
        chk_dut("C", mc, 34, 2, 3, 1, 32'(ifc.o_Sel), 32'(ifc.o_Anodos), 32'(ifc.o_Digit),
                32'(ifc.o_Dp), 32'(ifc.o_Tick), 32'(ifc.o_Frame));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifa.i_En = 1'b0; ifb.i_En = 1'b0;
`ifdef SCAN_DIMMING_EN
        ifc.i_En = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
        ma = mreset(); mb = mreset(); mc = mreset();
    endtask

    typedef struct {
        int          adv;
        bit          en;
        logic [11:0] data;
        logic [2:0]  sel;
        logic [2:0]  an;
        logic [3:0]  dig;
        bit          tk;
        bit          fr;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        tbl[0]  = '{1, 1'b1, 12'h3A5, 3'd0, 3'b000, 4'h5, 1'b1, 1'b1};
        tbl[1]  = '{1, 1'b1, 12'h3A5, 3'd0, 3'b000, 4'h5, 1'b0, 1'b0};
        tbl[2]  = '{1, 1'b1, 12'h3A5, 3'd0, 3'b001, 4'h5, 1'b0, 1'b0};
        tbl[3]  = '{5, 1'b1, 12'h3A5, 3'd0, 3'b001, 4'h5, 1'b0, 1'b0};
        tbl[4]  = '{1, 1'b1, 12'h3A5, 3'd1, 3'b000, 4'hA, 1'b1, 1'b0};
        tbl[5]  = '{2, 1'b1, 12'h3A5, 3'd1, 3'b010, 4'hA, 1'b0, 1'b0};
        tbl[6]  = '{6, 1'b1, 12'h777, 3'd2, 3'b000, 4'h3, 1'b1, 1'b0};
        tbl[7]  = '{2, 1'b1, 12'h777, 3'd2, 3'b100, 4'h3, 1'b0, 1'b0};
        tbl[8]  = '{6, 1'b1, 12'h777, 3'd0, 3'b000, 4'h7, 1'b1, 1'b1};
        tbl[9]  = '{2, 1'b1, 12'h777, 3'd0, 3'b001, 4'h7, 1'b0, 1'b0};
        tbl[10] = '{8, 1'b1, 12'h777, 3'd1, 3'b010, 4'h7, 1'b0, 1'b0};
        tbl[11] = '{1, 1'b0, 12'h777, 3'd0, 3'b000, 4'h7, 1'b0, 1'b0};
        tbl[12] = '{3, 1'b0, 12'h777, 3'd0, 3'b000, 4'h7, 1'b0, 1'b0};
        tbl[13] = '{1, 1'b1, 12'h777, 3'd0, 3'b000, 4'h7, 1'b1, 1'b1};
        tbl[14] = '{1, 1'b1, 12'h777, 3'd0, 3'b000, 4'h7, 1'b0, 1'b0};
        tbl[15] = '{1, 1'b1, 12'h777, 3'd0, 3'b001, 4'h7, 1'b0, 1'b0};
        tbl[16] = '{6, 1'b1, 12'h777, 3'd1, 3'b000, 4'h7, 1'b1, 1'b0};

        ifa.i_En = 1'b0; ifa.i_Data = '0; ifa.i_DpMask = '0;
        ifb.i_En = 1'b0; ifb.i_Data = '0; ifb.i_DpMask = '0;
`ifdef SCAN_DIMMING_EN
        ifc.i_En = 1'b0; ifc.i_Data = '0; ifc.i_DpMask = '0; ifc.i_Bright = 4'd15;
`endif
        do_reset();
        #1;
        check_all();

        // Async reset in the middle of a SHOW cycle, no clock edge involved.
        ifa.i_En = 1'b1; ifa.i_Data = 12'h3A5;
        repeat (3) cyc();
        chk("rst.pre_anodos", 32'(ifa.o_Anodos), 32'b001);
        #2 rst = 1'b1;
        #1;
        chk("rst.anodos", 32'(ifa.o_Anodos), 32'b000);
        chk("rst.sel", 32'(ifa.o_Sel), 0);
        chk("rst.digit", 32'(ifa.o_Digit), 0);
        chk("rst.tick", 32'(ifa.o_Tick), 0);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            ifa.i_En = tbl[i].en; ifa.i_Data = tbl[i].data; ifa.i_DpMask = '0;
            repeat (tbl[i].adv) cyc();
            chk($sformatf("tbl%0d.sel", i), 32'(ifa.o_Sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d.anodos", i), 32'(ifa.o_Anodos), 32'(tbl[i].an));
            chk($sformatf("tbl%0d.digit", i), 32'(ifa.o_Digit), 32'(tbl[i].dig));
            chk($sformatf("tbl%0d.tick", i), 32'(ifa.o_Tick), 32'(tbl[i].tk));
            chk($sformatf("tbl%0d.frame", i), 32'(ifa.o_Frame), 32'(tbl[i].fr));
        end

        // Active-low 4-digit instance: blank level, slot 0/3 patterns, decimal point only in slot 2.
        do_reset();
        ifb.i_En = 1'b1; ifb.i_Data = 16'h4321; ifb.i_DpMask = 4'b0100;
        cyc();
        chk("B.blank", 32'(ifb.o_Anodos), 32'b1111);
        repeat (2) cyc();
        chk("B.slot0", 32'(ifb.o_Anodos), 32'b1110);
        chk("B.dp0", 32'(ifb.o_Dp), 0);
        repeat (14) cyc();
        chk("B.sel2", 32'(ifb.o_Sel), 2);
        chk("B.dp2", 32'(ifb.o_Dp), 1);
        repeat (10) cyc();
        chk("B.slot3", 32'(ifb.o_Anodos), 32'b0111);
        chk("B.dp3", 32'(ifb.o_Dp), 0);

`ifdef SCAN_DIMMING_EN
        do_reset();
        ifc.i_En = 1'b1; ifc.i_Data = 12'h123; ifc.i_Bright = 4'd7;
        cnt = 0;
        repeat (34) begin cyc(); if (ifc.o_Anodos != '0) cnt++; end
        chk("C.on_b7", 32'(cnt), 16);
        ifc.i_Bright = 4'd15;
        cnt = 0;
        repeat (34) begin cyc(); if (ifc.o_Anodos != '0) cnt++; end
        chk("C.on_b15", 32'(cnt), 32);
`endif

        do_reset();
        ifa.i_En = 1'b1; ifb.i_En = 1'b1;
`ifdef SCAN_DIMMING_EN
        ifc.i_En = 1'b1;
`endif
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) ifa.i_En = ~ifa.i_En;
            if ($urandom_range(0, 99) < 3) ifb.i_En = ~ifb.i_En;
            if ($urandom_range(0, 3) == 0) ifa.i_Data = 12'($urandom);
            if ($urandom_range(0, 3) == 0) ifb.i_Data = 16'($urandom);
            ifa.i_DpMask = 3'($urandom);
            ifb.i_DpMask = 4'($urandom);
`ifdef SCAN_DIMMING_EN
            if ($urandom_range(0, 199) < 3) ifc.i_En = ~ifc.i_En;
            ifc.i_Data   = 12'($urandom);
            ifc.i_DpMask = 3'($urandom);
            ifc.i_Bright = 4'($urandom);
`endif
            cyc();
            check_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scan_anillo_n.md
Name: scan_anillo_n

Overview:
Parametrised multiplexed-display scanner. It drives N_DIGITS common-anode or common-cathode digits and generalises the fixed 4-digit free-running ring selector. It adds:
- a refresh prescaler
- anti-ghosting blank time per slot
- frame-coherent data snapshot
- a digit-value mux with decimal point
- enable control

It sits between the digit-value registers and the seven-segment decoder/pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8).
DIG_W, 4, bits per digit value.
PRESC, 50000, clock cycles per digit slot (must be >= BLANK+2).
BLANK, 16, leading cycles of each slot with all anodes inactive (must be >= 1).
ANODE_ACT, 1, anode active level (1 = active-high, 0 = active-low).
SEL_W (localparam), max(1, clog2(N_DIGITS)).

Ports:
i_Clk  input  1  system clock.
i_Reset  input  1  asynchronous reset, active-high.
i_En  input  1  scan enable.
i_Data  input  N_DIGITS*DIG_W  digit values; digit k = i_Data[k*DIG_W +: DIG_W].
i_DpMask  input  N_DIGITS  decimal point per digit.
o_Sel  output  SEL_W  current digit index.
o_Anodos  output  N_DIGITS  one-hot anode drive at ANODE_ACT level.
o_Digit  output  DIG_W  value of current digit (from snapshot).
o_Dp  output  1  decimal point of current digit.
o_Tick  output  1  one-cycle pulse on first cycle of every slot.
o_Frame  output  1  one-cycle pulse on first cycle of slot 0.

Behaviour:
- Internal state:
  - slot counter p (0..PRESC-1)
  - sel (0..N_DIGITS-1)
  - snapshot registers snapD/snapDp
  - FSM {IDLE, BLANK, SHOW}
- All outputs are registered and updated on the same edge as the state they reflect (no extra latency).
- Reset (async, immediate, no clock needed):
  - FSM=IDLE, p=0, sel=0, snapshot=0
  - o_Anodos all inactive (ANODE_ACT ? 0 : all-ones)
  - o_Sel=0, o_Digit=0, o_Dp=0, o_Tick=0, o_Frame=0
- IDLE, i_En=0: hold. IDLE, i_En=1: next edge goes to BLANK with p=0, sel=0, snapshot<=i_Data/i_DpMask, and o_Tick=1 and o_Frame=1 for that cycle.
- Each edge while enabled:
  - If p==PRESC-1: p<=0, sel<=(sel==N_DIGITS-1)?0:sel+1, FSM<=BLANK, o_Tick=1.
  - If the new sel is 0: re-capture snapshot and pulse o_Frame.
  - Otherwise p<=p+1.
  - BLANK->SHOW on the edge where p becomes BLANK.
- Anodes:
  - In IDLE/BLANK, all anodes are inactive.
  - In SHOW, only bit sel is active.
  - Never more than one anode is active, and none is active in the cycle sel changes.
- o_Digit and o_Dp take snapD[sel] and snapDp[sel] from the first cycle of the slot, i.e. they are stable through BLANK.
- Wrap: sel never reaches N_DIGITS for non-power-of-2 N_DIGITS.
- Data coherency: i_Data changes mid-frame are invisible until the next slot-0 capture.
- i_En deasserted in any state: next edge FSM=IDLE, p=0, sel=0, anodes inactive, tick/frame 0; snapshot retained.
- Re-enable always restarts at slot 0 with blanking.

Optional Feature:
Macro SCAN_DIMMING_EN.
- Defined:
  - Adds input i_Bright [3:0], sampled at each slot start.
  - SHOW lasts only while p < BLANK + L, where L = ((PRESC-BLANK)*(i_Bright+1))>>4, computed from the sampled value.
  - For the remainder of the slot, FSM returns to BLANK and anodes are inactive.
  - i_Bright=15 gives full on-time.
- Undefined: port absent; SHOW always lasts to the end of the slot.

Test Plan:
1. N_DIGITS=3, PRESC=8, BLANK=2, ANODE_ACT=1. Assert i_Reset mid-SHOW without a clock edge -> o_Anodos=000 immediately; o_Sel=0, o_Digit=0.
2. Same config, i_En=1, i_Data=12'h3A5.
   - Slot 0: p0-1 anodes 000 with digit 5, p2-7 anodes 001.
   - Slot 1: digit A, anodes 010. Slot 2: digit 3, anodes 100.
   - Then sel returns to 0 with o_Frame=1; sel never equals 3; o_Tick every 8 cycles.
3. While sel=1, change i_Data to 12'h777 -> slots 1 and 2 still show A and 3; from the next frame all slots show 7.
4. Drop i_En during slot 1 SHOW -> next edge anodes 000, sel 0. Raise i_En -> slot 0 blank for 2 cycles, then anode 001.
5. N_DIGITS=4, ANODE_ACT=0, PRESC=8, BLANK=2 -> blank anodes 1111; slot 0 SHOW 1110; slot 3 SHOW 0111; i_DpMask=4'b0100 -> o_Dp=1 only in slot 2.
6. SCAN_DIMMING_EN, PRESC=34, BLANK=2, i_Bright=7 -> 16 SHOW cycles (p2-17) and 16 blank cycles (p18-33) per slot. i_Bright=15 -> 32 SHOW cycles.
